// File: rtl/out_port_pkg.sv
// Shared definitions for the OUT-port display responder:
// slot/digit geometry, hex glyphs and output polarity helper.
package out_port_pkg;

    localparam int NUM_SLOTS  = 8;
    localparam int NUM_DIGITS = 8;

    typedef logic [31:0] slot_word_t;
    typedef logic [2:0]  slot_idx_t;
    typedef logic [2:0]  digit_idx_t;
    typedef logic [6:0]  glyph_t;

    localparam digit_idx_t DIGIT_LAST = 3'd7;

    // Active-high glyphs, bit order {g,f,e,d,c,b,a}
    localparam glyph_t SEG_0     = 7'b0111111;
    localparam glyph_t SEG_1     = 7'b0000110;
    localparam glyph_t SEG_2     = 7'b1011011;
    localparam glyph_t SEG_3     = 7'b1001111;
    localparam glyph_t SEG_4     = 7'b1100110;
    localparam glyph_t SEG_5     = 7'b1101101;
    localparam glyph_t SEG_6     = 7'b1111101;
    localparam glyph_t SEG_7     = 7'b0000111;
    localparam glyph_t SEG_8     = 7'b1111111;
    localparam glyph_t SEG_9     = 7'b1101111;
    localparam glyph_t SEG_A     = 7'b1110111;
    localparam glyph_t SEG_B     = 7'b1111100;
    localparam glyph_t SEG_C     = 7'b0111001;
    localparam glyph_t SEG_D     = 7'b1011110;
    localparam glyph_t SEG_E     = 7'b1111001;
    localparam glyph_t SEG_F     = 7'b1110001;
    localparam glyph_t SEG_BLANK = 7'b0000000;

    // Map an active-high pin vector onto the board polarity
    function automatic logic [7:0] to_pins(
        input logic [7:0] v,
        input bit         active_low
    );
        return active_low ? ~v : v;
    endfunction

endpackage

// File: rtl/out_port_display_hex_to_seg7.sv
// Combinational hex nibble to active-high seven-segment glyph.
// Polarity and decimal point are handled by the caller.
module hex_to_seg7
    import out_port_pkg::*;
(
    input  logic [3:0] i_nib,
    output glyph_t     o_glyph
);

    // Pure lookup of the standard hex glyph set
    always_comb begin
        o_glyph = SEG_BLANK;
        case (i_nib)
            4'h0: o_glyph = SEG_0;
            4'h1: o_glyph = SEG_1;
            4'h2: o_glyph = SEG_2;
            4'h3: o_glyph = SEG_3;
            4'h4: o_glyph = SEG_4;
            4'h5: o_glyph = SEG_5;
            4'h6: o_glyph = SEG_6;
            4'h7: o_glyph = SEG_7;
            4'h8: o_glyph = SEG_8;
            4'h9: o_glyph = SEG_9;
            4'hA: o_glyph = SEG_A;
            4'hB: o_glyph = SEG_B;
            4'hC: o_glyph = SEG_C;
            4'hD: o_glyph = SEG_D;
            4'hE: o_glyph = SEG_E;
            4'hF: o_glyph = SEG_F;
            default: o_glyph = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/out_port_display.sv
// OUT-port responder: captures value pairs into 8 slots and
// scans the selected slot onto an 8-digit seven-segment display.
module out_port_display
    import out_port_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        outdisplay,
    input  logic [2:0]  outsel,
    input  logic [15:0] outval1,
    input  logic [15:0] outval2,
    input  logic [2:0]  view_sel,
    output logic [7:0]  seg,
    output logic [7:0]  an,
    output logic [7:0]  updated,
    output logic [2:0]  last_sel
);

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
    localparam logic [7:0]  PIN_IDLE = to_pins(8'h00, SEG_ACTIVE_LOW);

    slot_word_t  r_slots [NUM_SLOTS];
    slot_idx_t   r_last_sel;
    logic [7:0]  r_updated;
    logic [15:0] r_div;
    digit_idx_t  r_digit;
    logic [7:0]  r_seg;
    logic [7:0]  r_an;

    logic        w_tick;
    logic        w_frame_end;
    slot_word_t  w_view_word;
    logic [3:0]  w_nib;
    glyph_t      w_glyph;
    logic        w_dp;
    logic [7:0]  w_seg_hi;
    logic [7:0]  w_an_hi;
    logic [7:0]  w_upd_next;

    // Capture the value pair into the addressed slot on a strobe
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_slots[i] <= '0;
            end
            r_last_sel <= '0;
        end else if (outdisplay) begin
            r_slots[outsel] <= {outval1, outval2};
            r_last_sel      <= outsel;
        end
    end

    // Digit dwell divider: terminal count yields a one-cycle tick
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 16'd1;
        end
    end

    assign w_tick      = (r_div == DIV_LAST);
    assign w_frame_end = w_tick && (r_digit == DIGIT_LAST);

    // Advance the scanned digit on each tick, wrapping 7 -> 0
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_digit <= '0;
        end else if (w_tick) begin
            r_digit <= r_digit + 3'd1;
        end
    end

    // Viewed slot flag drops after a full frame; a capture wins
    always_comb begin
        w_upd_next = r_updated;
        if (w_frame_end) begin
            w_upd_next[view_sel] = 1'b0;
        end
        if (outdisplay) begin
            w_upd_next[outsel] = 1'b1;
        end
    end

    // Hold the per-slot written-since-viewed flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_updated <= '0;
        end else begin
            r_updated <= w_upd_next;
        end
    end

    assign w_view_word = r_slots[view_sel];
    assign w_nib       = w_view_word[{r_digit, 2'b00} +: 4];

    hex_to_seg7 u_hex (
        .i_nib   (w_nib),
        .o_glyph (w_glyph)
    );

    assign w_dp     = (r_digit == '0) && r_updated[view_sel];
    assign w_seg_hi = {w_dp, w_glyph};
    assign w_an_hi  = 8'h01 << r_digit;

    // Register pin drive so segments and anodes switch together
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_seg <= PIN_IDLE;
            r_an  <= PIN_IDLE;
        end else begin
            r_seg <= to_pins(w_seg_hi, SEG_ACTIVE_LOW);
            r_an  <= to_pins(w_an_hi, SEG_ACTIVE_LOW);
        end
    end

    assign seg      = r_seg;
    assign an       = r_an;
    assign updated  = r_updated;
    assign last_sel = r_last_sel;

endmodule

// File: doc/out_port_display.md
Name: out_port_display

Overview:
- Responder for the processor's output interface (outdisplay/outsel/outval1/outval2).
- On each OUT pulse, captures the 32-bit value pair into one of 8 slots selected by outsel.
- Time-multiplexes the slot chosen by view_sel onto an 8-digit common-anode seven-segment display as 8 hex digits.
- Sits at board top level between the processor core and the display pins.

Parameters:
- SCAN_DIV, 50000, clock cycles per digit dwell; legal range 1..65535.
- SEG_ACTIVE_LOW, 1, 1 = seg and an outputs active-low; 0 = outputs inverted to active-high.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high
- outdisplay  input  1  one-cycle capture strobe from processor OUT
- outsel  input  3  destination slot index
- outval1  input  16  upper half of captured value (digits 7..4)
- outval2  input  16  lower half of captured value (digits 3..0)
- view_sel  input  3  slot shown on the display (board switches, synchronous to clock)
- seg  output  8  {dp,g,f,e,d,c,b,a} segment drive
- an  output  8  digit enables, bit i = digit i
- updated  output  8  per-slot "written since last full view" flags
- last_sel  output  3  slot index of the most recent capture

Behaviour:
- Clock and reset: clock is clock; reset is reset, asynchronous, active-high.
- Reset values:
  - all slots 0x00000000
  - divider 0, digit index 0
  - an all inactive, seg all inactive (0xFF when SEG_ACTIVE_LOW=1)
  - updated 0, last_sel 0
- Capture:
  - At posedge with outdisplay=1: slot[outsel] <= {outval1,outval2}, updated[outsel] <= 1, last_sel <= outsel.
  - The slot value is visible on the next clock.
  - Back-to-back strobes each capture independently; consecutive strobes to the same slot leave the last value.
  - outdisplay=0: no slot changes.
- Scan divider:
  - Counts 0..SCAN_DIV-1; the terminal count raises tick for one cycle and the divider wraps to 0.
  - On tick, digit index increments mod 8 (7 wraps to 0).
  - SCAN_DIV=1: tick every cycle.
- Digit mapping: digit i displays nibble i of slot[view_sel], i.e. bits [4i+3:4i] of {outval1,outval2}. Digit 0 = outval2[3:0]; digit 7 = outval1[15:12].
- Decoding:
  - Hex 0-F uses standard seven-segment glyphs.
  - dp is lit only on digit 0, and only when updated[view_sel]=1.
- Output timing:
  - seg and an are registered. They reflect the digit index, slot contents and view_sel sampled on the previous clock (1-cycle latency).
  - Exactly one an bit is active at any time after the first clock following reset release.
- Clearing updated:
  - updated[view_sel] clears on the tick where the digit index wraps 7->0, meaning a full frame was shown.
  - If a capture to slot k and a clear of slot k occur in the same cycle, set wins (updated[k]=1).
- view_sel change: takes effect on the next registered output. The divider and digit index are not reset.
- Reset mid-frame: immediate return to reset values; scanning restarts at digit 0 with the divider at 0.

Decomposition:
- Shared package out_port_pkg:
  - NUM_SLOTS=8, NUM_DIGITS=8
  - 7-bit glyph constants SEG_0..SEG_F (active-high, gfedcba)
  - SEG_BLANK
- Sub-module hex_to_seg7: combinational 4-bit -> 7-bit active-high glyph. Polarity inversion and dp are applied in out_port_display.

Test Plan:
- Reset: assert reset mid-scan -> seg=0xFF, an=0xFF, updated=0, last_sel=0 immediately. After release, with SCAN_DIV=4, an steps 0xFE, 0xFD, ... every 4 cycles and wraps after 0x7F.
- Basic capture: SCAN_DIV=2, outdisplay pulse, outsel=3, outval1=0x1234, outval2=0xABCD, view_sel=3 -> digit 0 shows glyph D (seg[6:0] active-low 0b0100001) with dp lit; digit 7 shows glyph 1; updated=0x08, last_sel=3.
- Updated clear: continue the previous case through one full 8-digit frame -> updated[3]=0 after the 7->0 wrap tick; dp on digit 0 goes dark.
- Set-wins collision: capture to slot 3 on the exact cycle of the 7->0 wrap tick with view_sel=3 -> updated[3] remains 1.
- Back-to-back captures: consecutive-cycle pulses with (sel 5, 0x0000_0001), (sel 5, 0x0000_0002), (sel 6, 0xFFFF_FFFF) -> slot5=0x00000002, slot6=0xFFFFFFFF, last_sel=6, updated=0x60. view_sel=6 shows glyph F on all digits.
- SCAN_DIV=1 and view switch: digit advances every cycle. Changing view_sel 6->5 mid-frame makes the next registered seg show slot 5's nibble for the current digit, and an continues its sequence without restart.
